// File: rtl/updown_counter_p.sv
// updown_counter_p: parametrised up/down modulo counter.
//
// The counter counts over 0..MODULUS-1 in either direction. It has a synchronous load with
// clamping, a registered one-cycle terminal-count pulse on every wrap, and a sticky overflow
// flag.
//
// Optional feature macro: UPDN_COUNTER_SAT_EN
//   When defined, a `sat` input is present. With sat=1, an enabled step at the limit holds
//   the count, produces no tc pulse and sets ovf. When the macro is undefined there is no
//   sat port and the counter always wraps.
//
// Parameters
//   WIDTH    counter/data width in bits (>= 1)
//   MODULUS  count range is 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset; clears cnt, tc and ovf
//   load     synchronous load of data, clamped to MODULUS-1 (beats en)
//   data     load value
//   en       count enable
//   up       direction: 1 = up, 0 = down
//   ovf_clr  clears the sticky ovf (a simultaneous wrap wins)
//   sat      saturate select (UPDN_COUNTER_SAT_EN only)
//   cnt      registered count
//   zero     combinational cnt == 0
//   tc       registered one-cycle wrap pulse, high while cnt shows the wrapped value
//   ovf      sticky wrap/saturation flag
module updown_counter_p #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MODULUS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up,
  input  logic             ovf_clr,
`ifdef UPDN_COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             zero,
  output logic             tc,
  output logic             ovf
);

  // Reject configurations whose range cannot be represented in WIDTH bits.
  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_cfg
    $error("updown_counter_p: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic             sat_mode;
  logic             at_limit;
  logic             limit_step;
  logic             wrap_ev;
  logic             sat_ev;

`ifdef UPDN_COUNTER_SAT_EN
  assign sat_mode = sat;
`else
  assign sat_mode = 1'b0;
`endif

  // Classify the step taken at this edge: a limit step either wraps or, in saturate
  // mode, is absorbed. Load suppresses both because it has priority over counting.
  always_comb begin
    at_limit   = up ? (cnt_q == MaxV) : (cnt_q == '0);
    limit_step = ~load & en & at_limit;
    wrap_ev    = limit_step & ~sat_mode;
    sat_ev     = limit_step & sat_mode;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (data > MaxV) ? MaxV : data;
    end else if (en) begin
      if (limit_step) begin
        // Saturated steps leave cnt_d at cnt_q.
        if (!sat_mode) begin
          cnt_d = up ? '0 : MaxV;
        end
      end else begin
        cnt_d = up ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
      end
    end
  end

  always_comb begin
    tc_d  = wrap_ev;
    ovf_d = ovf_q;
    if (wrap_ev || sat_ev) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign tc   = tc_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_updown_counter_p.sv
// Testbench for updown_counter_p: two instances (MODULUS 32 and 10, WIDTH 5) share one stimulus
// stream and are checked against a modular-arithmetic reference model.
module tb_updown_counter_p;

`ifdef UPDN_COUNTER_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [4:0] data;
  logic       en;
  logic       up;
  logic       ovf_clr;
  logic       sat;

  logic [4:0] cnt32, cnt10;
  logic       zero32, zero10, tc32, tc10, ovf32, ovf10;

  always #5 clk = ~clk;

  updown_counter_p #(.WIDTH(5), .MODULUS(32)) u_dut32 (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (data),
    .en      (en),
    .up      (up),
    .ovf_clr (ovf_clr),
`ifdef UPDN_COUNTER_SAT_EN
    .sat     (sat),
`endif
    .cnt     (cnt32),
    .zero    (zero32),
    .tc      (tc32),
    .ovf     (ovf32)
  );

  updown_counter_p #(.WIDTH(5), .MODULUS(10)) u_dut10 (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (data),
    .en      (en),
    .up      (up),
    .ovf_clr (ovf_clr),
`ifdef UPDN_COUNTER_SAT_EN
    .sat     (sat),
`endif
    .cnt     (cnt10),
    .zero    (zero10),
    .tc      (tc10),
    .ovf     (ovf10)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: index 0 is the MODULUS=32 instance, index 1 the MODULUS=10 instance.
  int mods [2] = '{32, 10};
  int m_cnt[2];
  bit m_tc [2];
  bit m_ovf[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_tc[i]  = 1'b0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit ld, input int d, input bit e, input bit u,
                                     input bit clr, input bit s);
    for (int i = 0; i < 2; i++) begin
      int  maxv;
      int  nxt;
      bit  crossed;
      bit  wrap;
      bit  hit;
      maxv = mods[i] - 1;
      wrap = 1'b0;
      hit  = 1'b0;
      if (ld) begin
        m_cnt[i] = (d > maxv) ? maxv : d;
        m_tc[i]  = 1'b0;
      end else if (e) begin
        nxt     = (m_cnt[i] + (u ? 1 : mods[i] - 1)) % mods[i];
        crossed = u ? (nxt < m_cnt[i]) : (nxt > m_cnt[i]);
        if (crossed && s && SatEn) begin
          hit = 1'b1;
        end else begin
          wrap     = crossed;
          m_cnt[i] = nxt;
        end
        m_tc[i] = wrap;
      end else begin
        m_tc[i] = 1'b0;
      end
      if (wrap || hit) m_ovf[i] = 1'b1;
      else if (clr)    m_ovf[i] = 1'b0;
    end
  endfunction

  function automatic logic [7:0] exp_of(input int i);
    return {5'(m_cnt[i]), m_cnt[i] == 0, m_tc[i], m_ovf[i]};
  endfunction

  function automatic logic [7:0] got_of(input int i);
    return (i == 0) ? {cnt32, zero32, tc32, ovf32} : {cnt10, zero10, tc10, ovf10};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1ns past it.
  task automatic drive_step(input bit ld, input int d, input bit e, input bit u,
                            input bit clr, input bit s);
    load    = ld;
    data    = 5'(d);
    en      = e;
    up      = u;
    ovf_clr = clr;
    sat     = s;
    @(posedge clk);
    model_step(ld, d, e, u, clr, s);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; data = '0; en = 1'b0; up = 1'b0; ovf_clr = 1'b0; sat = 1'b0;
    model_reset();
    #12;
    n_vec++;
    if ({cnt32, zero32, tc32, ovf32} !== 8'b00000_1_0_0) begin
      n_err++;
      $display("FAIL reset dut32: got %h want %h", {cnt32, zero32, tc32, ovf32}, 8'b00000100);
    end
    n_vec++;
    if ({cnt10, zero10, tc10, ovf10} !== 8'b00000_1_0_0) begin
      n_err++;
      $display("FAIL reset dut10: got %h want %h", {cnt10, zero10, tc10, ovf10}, 8'b00000100);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_async_reset();
    drive_step(1'b1, 31, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_step(1'b1, 'h13, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({cnt32, ovf32} !== {5'h13, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset dut32: got cnt=%h ovf=%b want cnt=13 ovf=1", cnt32, ovf32);
    end
    en = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_of(i) !== 8'b00000_1_0_0) begin
        n_err++;
        $display("FAIL async_reset dut%0d: got %h want %h", mods[i], got_of(i), 8'b00000100);
      end
    end
    #1 rst = 1'b1;
    drive_step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_of(i) !== {5'd1, 3'b000}) begin
        n_err++;
        $display("FAIL reset_release dut%0d: got %h want %h", mods[i], got_of(i), {5'd1, 3'b000});
      end
    end
  endtask

  task automatic test_wrap_up();
    drive_step(1'b1, 'h1e, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({cnt32, tc32} !== {5'h1f, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_up_pre dut32: got cnt=%h tc=%b want cnt=1f tc=0", cnt32, tc32);
    end
    drive_step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({cnt32, zero32, tc32, ovf32} !== 8'b00000_1_1_1) begin
      n_err++;
      $display("FAIL wrap_up dut32: got %h want %h", {cnt32, zero32, tc32, ovf32}, 8'b00000111);
    end
    drive_step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_of(i) !== exp_of(i)) begin
        n_err++;
        $display("FAIL wrap_up_post dut%0d: got %h want %h", mods[i], got_of(i), exp_of(i));
      end
    end
  endtask

  task automatic test_wrap_down();
    drive_step(1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({cnt10, zero10, tc10, ovf10} !== {5'd9, 3'b011}) begin
      n_err++;
      $display("FAIL wrap_down dut10: got %h want %h", {cnt10, zero10, tc10, ovf10},
               {5'd9, 3'b011});
    end
    drive_step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({cnt10, zero10, tc10, ovf10} !== {5'd8, 3'b001}) begin
      n_err++;
      $display("FAIL wrap_down_next dut10: got %h want %h", {cnt10, zero10, tc10, ovf10},
               {5'd8, 3'b001});
    end
    n_vec++;
    if (got_of(0) !== exp_of(0)) begin
      n_err++;
      $display("FAIL wrap_down dut32: got %h want %h", got_of(0), exp_of(0));
    end
  endtask

  task automatic test_load_clamp();
    drive_step(1'b1, 'h17, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({cnt10, tc10} !== {5'd9, 1'b0}) begin
      n_err++;
      $display("FAIL load_clamp dut10: got cnt=%h tc=%b want cnt=09 tc=0", cnt10, tc10);
    end
    n_vec++;
    if ({cnt32, tc32} !== {5'h17, 1'b0}) begin
      n_err++;
      $display("FAIL load_noclamp dut32: got cnt=%h tc=%b want cnt=17 tc=0", cnt32, tc32);
    end
  endtask

  task automatic test_ovf_clr();
    drive_step(1'b1, 31, 1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({ovf32, ovf10} !== 2'b00) begin
      n_err++;
      $display("FAIL ovf_clr_pre: got %b want 00", {ovf32, ovf10});
    end
    drive_step(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({ovf32, ovf10, tc32, tc10} !== 4'b1111) begin
      n_err++;
      $display("FAIL ovf_set_wins: got ovf/tc=%b want 1111", {ovf32, ovf10, tc32, tc10});
    end
    drive_step(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({ovf32, ovf10} !== 2'b00) begin
      n_err++;
      $display("FAIL ovf_clr: got %b want 00", {ovf32, ovf10});
    end
  endtask

`ifdef UPDN_COUNTER_SAT_EN
  task automatic test_sat();
    drive_step(1'b1, 31, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if ({cnt32, zero32, tc32, ovf32} !== {5'h1f, 3'b001}) begin
      n_err++;
      $display("FAIL sat_hold dut32: got %h want %h", {cnt32, zero32, tc32, ovf32},
               {5'h1f, 3'b001});
    end
    n_vec++;
    if ({cnt10, tc10, ovf10} !== {5'd9, 2'b01}) begin
      n_err++;
      $display("FAIL sat_hold dut10: got cnt=%h tc=%b ovf=%b want 09/0/1", cnt10, tc10, ovf10);
    end
  endtask
`endif

  task automatic test_back_to_back();
    drive_step(1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_step(1'b0, 0, 1'b1, k[0], 1'b0, 1'b0);
      n_vec++;
      if ({tc32, tc10} !== 2'b11) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got tc=%b want 11", k, {tc32, tc10});
      end
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (got_of(i) !== exp_of(i)) begin
          n_err++;
          $display("FAIL back_to_back[%0d] dut%0d: got %h want %h", k, mods[i], got_of(i),
                   exp_of(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (got_of(i) !== exp_of(i)) begin
            n_err++;
            $display("FAIL random_reset[%0d] dut%0d: got %h want %h", k, mods[i], got_of(i),
                     exp_of(i));
          end
        end
        #1 rst = 1'b1;
      end
      drive_step($urandom_range(0, 9) == 0, int'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (got_of(i) !== exp_of(i)) begin
          n_err++;
          $display("FAIL random[%0d] dut%0d: got %h want %h", k, mods[i], got_of(i), exp_of(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_wrap_up();
    test_wrap_down();
    test_load_clamp();
    test_ovf_clr();
`ifdef UPDN_COUNTER_SAT_EN
    test_sat();
`endif
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
